// File: rtl/multicore_pkg.sv
// multicore_pkg: shared state encoding and default sizes for the multicore launcher
package multicore_pkg;
  localparam int CORE_COUNT = 4;
  localparam int CNT_WIDTH = 24;
  typedef enum logic [2:0] {IDLE, WAIT_READY, START, RUN, FINISH} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: unsigned up-counter with sync clear that sticks at all-ones (ports: clk, rst, clr, inc, count)
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  assign count = count_q;
endmodule

// File: rtl/multicore_launcher.sv
// multicore_launcher: waits for masked cores ready, pulses start, gathers done, reports elapsed cycles (ports: launch/coreMask in, coreReady/coreDone from cores, coreStart to cores, busy/allDone/cycleCount status)
module multicore_launcher
  import multicore_pkg::*;
#(
  parameter int CORE_COUNT = multicore_pkg::CORE_COUNT,
  parameter int CNT_WIDTH = multicore_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch,
  input  logic [CORE_COUNT-1:0] coreMask,
  input  logic [CORE_COUNT-1:0] coreReady,
  input  logic [CORE_COUNT-1:0] coreDone,
  output logic [CORE_COUNT-1:0] coreStart,
  output logic                  busy,
  output logic                  allDone,
  output logic [CNT_WIDTH-1:0]  cycleCount
);
  state_t state_q;
  logic [CORE_COUNT-1:0] mask_q, done_seen_q;
  logic all_ready, all_done, cnt_clr, cnt_inc;
  assign all_ready = (coreReady & mask_q) == mask_q;
  // Dones arriving this cycle count toward completion without waiting for doneSeen to update.
  assign all_done = ((done_seen_q | coreDone) & mask_q) == mask_q;
  assign cnt_clr = (state_q == IDLE && launch && coreMask == '0) || (state_q == WAIT_READY && all_ready);
  assign cnt_inc = state_q == START || state_q == RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      done_seen_q <= '0;
    end else
      case (state_q)
        IDLE:
          if (launch) begin
            if (coreMask != '0) begin
              mask_q <= coreMask;
              state_q <= WAIT_READY;
            end else state_q <= FINISH;
          end
        WAIT_READY:
          if (all_ready) begin
            done_seen_q <= '0;
            state_q <= START;
          end
        START: state_q <= RUN;
        RUN: begin
          done_seen_q <= done_seen_q | (coreDone & mask_q);
          if (all_done) state_q <= FINISH;
        end
        default: state_q <= IDLE;
      endcase
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .count(cycleCount)
  );
  assign coreStart = state_q == START ? mask_q : '0;
  assign busy = state_q != IDLE;
  assign allDone = state_q == FINISH;
endmodule
